// File: rtl/rom_segment_cache_pkg.sv
// rom_segment_cache_pkg: SDRAM widths and segment FSM encodings shared by the ROM front end
package rom_segment_cache_pkg;
  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    SEG_IDLE = 2'd0,
    SEG_REQ  = 2'd1,
    SEG_WAIT = 2'd2
  } seg_state_e;
endpackage

// File: rtl/rom_segment_cache_lane_mux.sv
// rom_segment_cache_lane_mux: picks a DW-bit lane from a 32-bit word, lane 0 in the top bits
module rom_segment_cache_lane_mux #(
  parameter int DW = 16,
  parameter int LW = 1
) (
  input  logic [31:0]   word,
  input  logic [LW-1:0] lane,
  output logic [DW-1:0] data
);
  localparam int L = 32 / DW;
  assign data = word[DW*(L-1-int'(lane)) +: DW];
endmodule

// File: rtl/rom_segment_cache.sv
// rom_segment_cache: one-word ROM cache in front of the SDRAM arbiter with req/ack/valid fill
module rom_segment_cache
  import rom_segment_cache_pkg::*;
#(
  parameter int          ROM_ADDR_WIDTH = 16,
  parameter int          ROM_DATA_WIDTH = 16,
  parameter logic [23:0] ROM_OFFSET     = 24'h000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cs,
  input  logic                        oe,
  input  logic [ROM_ADDR_WIDTH-1:0]   rom_addr,
  output logic [ROM_DATA_WIDTH-1:0]   rom_data,
  output logic [SDRAM_ADDR_WIDTH-1:0] ctrl_addr,
  output logic                        ctrl_req,
  input  logic                        ctrl_ack,
  input  logic                        ctrl_valid,
  output logic                        ctrl_hit,
  input  logic [SDRAM_DATA_WIDTH-1:0] ctrl_data
);
  localparam int L  = 32 / ROM_DATA_WIDTH;
  localparam int LB = $clog2(L);
  localparam int LW = LB > 0 ? LB : 1;
  localparam int WW = ROM_ADDR_WIDTH - LB;
  localparam logic [SDRAM_ADDR_WIDTH-1:0] BASE = SDRAM_ADDR_WIDTH'(ROM_OFFSET[23:2]);
  seg_state_e state_q, state_d;
  logic [WW-1:0] word_idx, line_tag_q, line_tag_d, req_tag_q, req_tag_d;
  logic [31:0] line_data_q, line_data_d;
  logic line_vld_q, line_vld_d;
  logic [LW-1:0] lane;
  logic rd, hit, fill, bypass;
  generate
    if (LB > 0) begin : g_lane
      assign lane = rom_addr[LW-1:0];
    end else begin : g_no_lane
      assign lane = '0;
    end
  endgenerate
  assign word_idx = rom_addr[ROM_ADDR_WIDTH-1:LB];
  assign rd       = cs & oe;
  assign hit      = line_vld_q & (line_tag_q == word_idx);
  assign fill     = (state_q == SEG_WAIT) & ctrl_valid;
  assign bypass   = fill & (req_tag_q == word_idx);
  assign ctrl_hit = rd & (hit | bypass);
  assign ctrl_req = state_q == SEG_REQ;
  // In IDLE the address tracks rom_addr so the arbiter sees it valid on the first REQ cycle
  assign ctrl_addr = BASE + SDRAM_ADDR_WIDTH'(state_q == SEG_IDLE ? word_idx : req_tag_q);
  rom_segment_cache_lane_mux #(.DW(ROM_DATA_WIDTH), .LW(LW)) u_lane_mux (
    .word (bypass ? ctrl_data : line_data_q),
    .lane (lane),
    .data (rom_data)
  );
  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    line_tag_d  = fill ? req_tag_q : line_tag_q;
    line_data_d = fill ? ctrl_data : line_data_q;
    line_vld_d  = line_vld_q | fill;
    if (state_q == SEG_IDLE) begin
      state_d   = rd & !hit ? SEG_REQ : SEG_IDLE;
      req_tag_d = rd & !hit ? word_idx : req_tag_q;
    end else if (state_q == SEG_REQ) begin
      state_d = ctrl_ack ? SEG_WAIT : SEG_REQ;
    end else begin
      state_d = ctrl_valid ? SEG_IDLE : SEG_WAIT;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEG_IDLE;
      req_tag_q   <= '0;
      line_tag_q  <= '0;
      line_data_q <= '0;
      line_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      line_tag_q  <= line_tag_d;
      line_data_q <= line_data_d;
      line_vld_q  <= line_vld_d;
    end
  end
endmodule
